// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for param_fifo
package fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  localparam int FWFT_STD  = 0;
  localparam int FWFT_FALL = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are intentionally not reset; the pointers decide what is valid.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised synchronous FIFO with standard or FWFT read
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_STD
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two in 2..1024");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("param_fifo: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [AW-1:0]    mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign data_out     = data_out_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // FWFT mode looks ahead at the head that will be current after this edge.
  assign mem_rd_addr = (FWFT == FWFT_FALL) ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];

  always_comb begin
    rd_acc      = en && rd && !empty;
    wr_acc      = en && wr && (!full || rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + ONE_C : rd_ptr_q;
    overflow_d  = en && wr && !wr_acc;
    underflow_d = en && rd && !rd_acc;
    data_out_d  = data_out_q;
    if (FWFT == FWFT_FALL) begin
      if (wr_ptr_d != rd_ptr_d) begin
        // The next head may be the slot being written on this very edge.
        data_out_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? data_in : mem_rd_data;
      end
    end else if (rd_acc) begin
      data_out_d = mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

endmodule
